mhpm_counter_bank: RTL and testbench

- Parametrised hardware performance monitor bank: mhpmcounter3..(3+NUM_CNT-1), their mhpmevent selectors and the matching mcountinhibit bits.
- Generalises the fixed NUM_MHPM/NUM_EVENTS scheme to configurable counter count, counter width, event count and inhibit mode.
- Adds registered event sampling and write/increment collision rules.
- Sits beside the machine CSR write/read logic. It is fed per-cycle event pulses from the pipeline and serves CSR reads and writes in the 0xB03-0xB1F, 0xB83-0xB9F, 0x323-0x33F and 0x320 address ranges.

---
 rtl/mhpm_counter_bank.sv | 176 +++++++++++++++++
 tb/tb_mhpm_counter_bank.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mhpm_counter_bank.sv
// Machine hardware performance counters (mhpmcounter3.., mhpmevent3.., mcountinhibit).
// Define MHPM_OVF_IRQ_EN to add per-counter overflow (OF) bits and the hpm_irq_out interrupt.
module mhpm_counter_bank #(
  parameter int          NUM_CNT      = 4,
  parameter int          NUM_EVENTS   = 24,
  parameter int          EV_SEL_SZ    = (NUM_EVENTS > 2) ? $clog2(NUM_EVENTS) : 1,
  parameter int          CNT_W        = 64,
  parameter int          SET_INHIBIT  = 0,
  parameter logic [31:0] INHIBIT_BITS = 32'h0000_0000
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [NUM_EVENTS-1:0] events_in,
  input  logic                  csr_wr_en_in,
  input  logic [11:0]           csr_wr_addr_in,
  input  logic [31:0]           csr_wr_data_in,
  input  logic [11:0]           csr_rd_addr_in,
  output logic [31:0]           csr_rd_data_out,
  output logic                  csr_rd_hit_out,
  output logic [31:0]           mcountinhibit_out,
  output logic                  hpm_irq_out
);

  localparam int          SEL_PAD  = 1 << EV_SEL_SZ;
  localparam logic [31:0] NUM_EV_W = 32'(NUM_EVENTS);
  localparam logic [31:0] INH_MASK = 32'(((64'd1 << NUM_CNT) - 64'd1) << 3);
  localparam logic [11:0] INH_ADDR = 12'h320;

  logic [NUM_EVENTS-1:0]             ev_q_reg;
  logic [SEL_PAD-1:0]                ev_pad;
  logic [31:0]                       inhibit_q;
  logic [NUM_CNT-1:0][CNT_W-1:0]     cnt_q;
  logic [NUM_CNT-1:0][EV_SEL_SZ-1:0] sel_q;
  logic [NUM_CNT-1:0]                of_q;
  logic [31:0]                       hi_word;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      ev_q_reg <= '0;
    end else begin
      ev_q_reg <= events_in;
    end
  end

  // Zero-padded so any selector value can index safely; out-of-range values are also gated below.
  always_comb begin
    ev_pad                   = '0;
    ev_pad[NUM_EVENTS-1:0]   = ev_q_reg;
  end

  generate
    if (SET_INHIBIT != 0) begin : gen_inh_const
      assign inhibit_q = INHIBIT_BITS;
    end else begin : gen_inh_reg
      logic [31:0] inhibit_reg;
      always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
          inhibit_reg <= '0;
        end else if (csr_wr_en_in && (csr_wr_addr_in == INH_ADDR)) begin
          inhibit_reg <= csr_wr_data_in & INH_MASK;
        end
      end
      assign inhibit_q = inhibit_reg;
    end
  endgenerate

  assign mcountinhibit_out = inhibit_q & ~32'h7;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : gen_cnt
      localparam logic [11:0] LO_ADDR  = 12'(12'hB03 + gi);
      localparam logic [11:0] HI_ADDR  = 12'(12'hB83 + gi);
      localparam logic [11:0] SEL_ADDR = 12'(12'h323 + gi);

      logic [CNT_W-1:0]     cnt_reg, cnt_next;
      logic [EV_SEL_SZ-1:0] sel_reg, sel_next;
      logic                 lo_wr, hi_wr, sel_wr, inc;

      assign lo_wr  = csr_wr_en_in && (csr_wr_addr_in == LO_ADDR);
      assign hi_wr  = csr_wr_en_in && (csr_wr_addr_in == HI_ADDR);
      assign sel_wr = csr_wr_en_in && (csr_wr_addr_in == SEL_ADDR);
      assign inc    = ev_pad[sel_reg] && (sel_reg != '0) && (32'(sel_reg) < NUM_EV_W)
                      && !inhibit_q[3+gi];

      // A write to either half suppresses the increment of the whole counter that cycle.
      always_comb begin
        cnt_next = cnt_reg;
        if (lo_wr || hi_wr) begin
          if (lo_wr) cnt_next[31:0] = csr_wr_data_in;
          if (hi_wr) cnt_next[CNT_W-1:32] = csr_wr_data_in[CNT_W-33:0];
        end else if (inc) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      always_comb begin
        sel_next = sel_reg;
        if (sel_wr) begin
          sel_next = (csr_wr_data_in < NUM_EV_W) ? csr_wr_data_in[EV_SEL_SZ-1:0] : '0;
        end
      end

      always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
          cnt_reg <= '0;
          sel_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
          sel_reg <= sel_next;
        end
      end

      assign cnt_q[gi] = cnt_reg;
      assign sel_q[gi] = sel_reg;

`ifdef MHPM_OVF_IRQ_EN
      logic of_reg;
      always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
          of_reg <= 1'b0;
        end else if (sel_wr) begin
          of_reg <= csr_wr_data_in[31];
        end else if (inc && !(lo_wr || hi_wr) && (cnt_reg == '1)) begin
          of_reg <= 1'b1;
        end
      end
      assign of_q[gi] = of_reg;
`else
      assign of_q[gi] = 1'b0;
`endif
    end
  endgenerate

`ifdef MHPM_OVF_IRQ_EN
  logic irq_reg;
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |of_q;
    end
  end
  assign hpm_irq_out = irq_reg;
`else
  assign hpm_irq_out = 1'b0;
`endif

  // Reads see register state only, so a same-cycle write or increment is not yet visible.
  always_comb begin
    csr_rd_data_out = '0;
    csr_rd_hit_out  = 1'b0;
    hi_word         = '0;
    if (csr_rd_addr_in == INH_ADDR) begin
      csr_rd_hit_out  = 1'b1;
      csr_rd_data_out = mcountinhibit_out;
    end
    for (int k = 0; k < NUM_CNT; k++) begin
      hi_word                = '0;
      hi_word[CNT_W-33:0]    = cnt_q[k][CNT_W-1:32];
      if (csr_rd_addr_in == 12'(12'hB03 + k)) begin
        csr_rd_hit_out  = 1'b1;
        csr_rd_data_out = cnt_q[k][31:0];
      end
      if (csr_rd_addr_in == 12'(12'hB83 + k)) begin
        csr_rd_hit_out  = 1'b1;
        csr_rd_data_out = hi_word;
      end
      if (csr_rd_addr_in == 12'(12'h323 + k)) begin
        csr_rd_hit_out  = 1'b1;
        csr_rd_data_out = {of_q[k], {(31-EV_SEL_SZ){1'b0}}, sel_q[k]};
      end
    end
  end

endmodule

// File: tb/tb_mhpm_counter_bank.sv
// Scoreboard bench for mhpm_counter_bank: stimulus queues expectations, a negedge monitor checks them.
module tb_mhpm_counter_bank;

  localparam int NUM_EVENTS = 24;
`ifdef MHPM_OVF_IRQ_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  localparam int K_RD  = 0;
  localparam int K_IRQ = 1;
  localparam int K_INH = 2;

  typedef struct {
    int          kind;
    logic        hit;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic                  clk;
  logic                  reset_in;
  logic [NUM_EVENTS-1:0] events_in;
  logic                  csr_wr_en;
  logic [11:0]           csr_wr_addr;
  logic [31:0]           csr_wr_data;
  logic [11:0]           csr_rd_addr;
  logic [31:0]           csr_rd_data_out;
  logic                  csr_rd_hit_out;
  logic [31:0]           mcountinhibit_out;
  logic                  hpm_irq_out;

  exp_t sb_q[$];
  logic chk_req;
  int   errors;
  int   checks;

  mhpm_counter_bank dut (
    .clk_in           (clk),
    .reset_in         (reset_in),
    .events_in        (events_in),
    .csr_wr_en_in     (csr_wr_en),
    .csr_wr_addr_in   (csr_wr_addr),
    .csr_wr_data_in   (csr_wr_data),
    .csr_rd_addr_in   (csr_rd_addr),
    .csr_rd_data_out  (csr_rd_data_out),
    .csr_rd_hit_out   (csr_rd_hit_out),
    .mcountinhibit_out(mcountinhibit_out),
    .hpm_irq_out      (hpm_irq_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Monitor: one expectation consumed per requested sample.
  always @(negedge clk) begin
    exp_t e;
    if (chk_req) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: sample requested, got empty queue, expected an entry");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_RD: begin
            if (csr_rd_hit_out !== e.hit || csr_rd_data_out !== e.data) begin
              errors++;
              $display("FAIL %s: got hit=%0b data=%08h, expected hit=%0b data=%08h",
                       e.name, csr_rd_hit_out, csr_rd_data_out, e.hit, e.data);
            end else begin
              $display("check %s: addr=%03h hit=%0b data=%08h ok", e.name, csr_rd_addr,
                       csr_rd_hit_out, csr_rd_data_out);
            end
          end
          K_IRQ: begin
            if (hpm_irq_out !== e.data[0]) begin
              errors++;
              $display("FAIL %s: got irq=%0b, expected irq=%0b", e.name, hpm_irq_out, e.data[0]);
            end else begin
              $display("check %s: irq=%0b ok", e.name, hpm_irq_out);
            end
          end
          default: begin
            if (mcountinhibit_out !== e.data) begin
              errors++;
              $display("FAIL %s: got inhibit=%08h, expected inhibit=%08h", e.name,
                       mcountinhibit_out, e.data);
            end else begin
              $display("check %s: inhibit=%08h ok", e.name, mcountinhibit_out);
            end
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request_sample();
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
    tick();
  endtask

  task automatic check_rd(input logic [11:0] a, input logic h, input logic [31:0] d,
                          input string n);
    exp_t e;
    csr_rd_addr = a;
    e = '{K_RD, h, d, n};
    sb_q.push_back(e);
    request_sample();
  endtask

  task automatic check_sig(input int kind, input logic [31:0] d, input string n);
    exp_t e;
    e = '{kind, 1'b0, d, n};
    sb_q.push_back(e);
    request_sample();
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    csr_wr_en   = 1'b1;
    csr_wr_addr = a;
    csr_wr_data = d;
    tick();
    csr_wr_en   = 1'b0;
    $display("write addr=%03h data=%08h", a, d);
  endtask

  // Write and read the same CSR in one cycle; the read must see the old value.
  task automatic check_rw(input logic [11:0] a, input logic [31:0] d, input logic [31:0] old_d,
                          input string n);
    exp_t e;
    csr_wr_en   = 1'b1;
    csr_wr_addr = a;
    csr_wr_data = d;
    csr_rd_addr = a;
    e = '{K_RD, 1'b1, old_d, n};
    sb_q.push_back(e);
    request_sample();
    csr_wr_en = 1'b0;
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    chk_req     = 1'b0;
    reset_in    = 1'b0;
    events_in   = '0;
    csr_wr_en   = 1'b0;
    csr_wr_addr = '0;
    csr_wr_data = '0;
    csr_rd_addr = '0;
    repeat (3) tick();
    reset_in = 1'b1;
    tick();

    check_rd(12'hB03, 1'b1, 32'h0, "rst_cnt3_lo");
    check_rd(12'hB83, 1'b1, 32'h0, "rst_cnt3_hi");
    check_rd(12'h323, 1'b1, 32'h0, "rst_sel3");
    check_rd(12'h320, 1'b1, 32'h0, "rst_inhibit");
    check_rd(12'hB07, 1'b0, 32'h0, "unimpl_cnt7");
    check_rd(12'h000, 1'b0, 32'h0, "unimpl_addr0");
    check_sig(K_IRQ, 32'h0, "rst_irq");
    check_sig(K_INH, 32'h0, "rst_inh_out");

    // Ten-cycle event burst with two-edge latency.
    csr_write(12'h323, 32'd5);
    events_in = 24'(1 << 5);
    check_rd(12'hB03, 1'b1, 32'd0, "lat_edge0");
    check_rd(12'hB03, 1'b1, 32'd0, "lat_edge1");
    check_rd(12'hB03, 1'b1, 32'd1, "lat_edge2");
    repeat (7) tick();
    events_in = '0;
    tick();
    check_rd(12'hB03, 1'b1, 32'd10, "burst10");
    check_rd(12'hB03, 1'b1, 32'd10, "burst10_hold");

    // 64-bit wrap-around.
    csr_write(12'hB83, 32'hFFFF_FFFF);
    csr_write(12'hB03, 32'hFFFF_FFFE);
    events_in = 24'(1 << 5);
    repeat (3) tick();
    events_in = '0;
    repeat (2) tick();
    check_rd(12'hB03, 1'b1, 32'h1, "wrap_lo");
    check_rd(12'hB83, 1'b1, 32'h0, "wrap_hi");
    check_rd(12'h323, 1'b1, OVF ? 32'h8000_0005 : 32'h5, "wrap_of_bit");
    check_sig(K_IRQ, {31'h0, OVF}, "wrap_irq");
    csr_write(12'h323, 32'd5);
    check_rd(12'h323, 1'b1, 32'h5, "of_cleared");
    check_sig(K_IRQ, 32'h0, "irq_cleared");

    // Inhibit freezes and resumes counter 3.
    csr_write(12'hB03, 32'd0);
    events_in = 24'(1 << 5);
    repeat (3) tick();
    csr_write(12'h320, 32'h8);
    repeat (3) tick();
    check_rd(12'hB03, 1'b1, 32'd3, "inh_frozen");
    check_sig(K_INH, 32'h8, "inh_out8");
    check_rd(12'h320, 1'b1, 32'h8, "inh_read8");
    csr_write(12'h320, 32'hFFFF_FFFF);
    check_rd(12'h320, 1'b1, 32'h78, "inh_writable_mask");
    check_rd(12'hB03, 1'b1, 32'd3, "inh_still_frozen");
    csr_write(12'h320, 32'h0);
    check_rd(12'hB03, 1'b1, 32'd3, "inh_resume_e0");
    check_rd(12'hB03, 1'b1, 32'd4, "inh_resume_e1");
    events_in = '0;
    repeat (2) tick();
    check_rd(12'hB03, 1'b1, 32'd6, "inh_resume_end");

    // Write collides with a pending increment: write wins, event lost.
    events_in = 24'(1 << 5);
    tick();
    events_in = '0;
    csr_write(12'hB03, 32'd100);
    check_rd(12'hB03, 1'b1, 32'd100, "coll_event_lost");
    check_rd(12'hB03, 1'b1, 32'd100, "coll_hold");
    events_in = 24'(1 << 5);
    tick();
    events_in = '0;
    repeat (2) tick();
    check_rd(12'hB03, 1'b1, 32'd101, "coll_next_event");

    // Selector WARL and last-event selection.
    csr_write(12'h323, 32'd24);
    check_rd(12'h323, 1'b1, 32'd0, "sel_warl_24");
    events_in = 24'(1 << 5);
    repeat (3) tick();
    events_in = '0;
    repeat (2) tick();
    check_rd(12'hB03, 1'b1, 32'd101, "sel_zero_stops");
    csr_write(12'h323, 32'h105);
    check_rd(12'h323, 1'b1, 32'd0, "sel_warl_fullcmp");
    csr_write(12'h323, 32'd23);
    check_rd(12'h323, 1'b1, 32'd23, "sel_23");
    events_in = 24'((1 << 23) | (1 << 5));
    repeat (2) tick();
    events_in = '0;
    repeat (2) tick();
    check_rd(12'hB03, 1'b1, 32'd103, "sel23_counts");
    check_rd(12'hB04, 1'b1, 32'd0, "cnt4_idle");
    check_rd(12'hB86, 1'b1, 32'd0, "cnt6_hi_hit");
    check_rd(12'h326, 1'b1, 32'd0, "sel6_hit");
    check_rd(12'h327, 1'b0, 32'd0, "sel7_miss");
    check_rd(12'hB87, 1'b0, 32'd0, "cnt7_hi_miss");

    // Same-cycle read and write of one CSR.
    check_rw(12'h324, 32'd7, 32'd0, "rw_old_value");
    check_rd(12'h324, 1'b1, 32'd7, "rw_new_value");

    // Asynchronous reset mid-count.
    events_in = 24'(1 << 23);
    repeat (2) tick();
    reset_in = 1'b0;
    check_rd(12'hB03, 1'b1, 32'd0, "async_rst_cnt");
    check_rd(12'h323, 1'b1, 32'd0, "async_rst_sel");
    events_in = '0;
    reset_in  = 1'b1;
    tick();

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
